// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared control definitions for the 5-stage core: sequencer
// states, register-zero constant, ALUOp codes, stage-control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrlState_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic ifidFlush;
    logic idexFlush;
    logic memwbBubble;
  } pipeCtl_t;

  localparam pipeCtl_t CTL_RUN    = 7'b1111000;
  localparam pipeCtl_t CTL_FREEZE = 7'b0000001;
  localparam pipeCtl_t CTL_OFF    = 7'b0000000;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports: clk, reset (async high), inc, clear (sync), value[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + ONE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer: load-use stalls, branch/jump squashes, memory
// freeze with timeout; drives PC/IF/ID/EX/MEM/WB enables, flushes and
// bubble, plus saturating stall/flush counters and sticky timeout_err.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  // With a limit of one, the first frozen cycle is already the last.
  localparam bit FIRST_IS_LAST = (MEM_TIMEOUT <= 1);
  localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);

  ctrlState_e state;
  ctrlState_e stateNxt;
  logic [7:0] waitCnt;
  logic [7:0] waitNxt;
  pipeCtl_t   ctl;
  pipeCtl_t   hzCtl;
  logic       loadUse;
  logic       lastWait;
  logic       stallInc;
  logic       flushInc;

  assign loadUse = ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) ||
                    (id_uses_rt && (ex_rt == id_rt)));

  // waitCnt holds frozen cycles already completed; this one is +1.
  assign lastWait = ({1'b0, waitCnt} + 9'd1) >= LIMIT;

  always_comb begin
    hzCtl = CTL_RUN;
    if (ex_branch_taken) begin
      hzCtl.ifidFlush = 1'b1;
      hzCtl.idexFlush = 1'b1;
    end else if (loadUse) begin
      hzCtl.pcWrite   = 1'b0;
      hzCtl.ifidWrite = 1'b0;
      hzCtl.idexFlush = 1'b1;
    end else if (id_jump) begin
      hzCtl.ifidFlush = 1'b1;
    end
  end

  always_comb begin
    ctl      = CTL_RUN;
    stateNxt = state;
    waitNxt  = waitCnt;
    if (reset) begin
      ctl = CTL_OFF;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_access && !dmem_ready) begin
            ctl      = CTL_FREEZE;
            waitNxt  = 8'd1;
            stateNxt = FIRST_IS_LAST ? ERR : MEM_WAIT;
          end else begin
            ctl = hzCtl;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            ctl      = hzCtl;
            waitNxt  = 8'd0;
            stateNxt = RUN;
          end else begin
            ctl = CTL_FREEZE;
            if (lastWait) begin
              stateNxt = ERR;
            end else begin
              waitNxt = waitCnt + 8'd1;
            end
          end
        end
        ERR: begin
          ctl = CTL_FREEZE;
        end
        default: begin
          ctl      = CTL_FREEZE;
          stateNxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= 8'd0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitNxt;
    end
  end

  assign pc_write     = ctl.pcWrite;
  assign ifid_write   = ctl.ifidWrite;
  assign idex_write   = ctl.idexWrite;
  assign exmem_write  = ctl.exmemWrite;
  assign ifid_flush   = ctl.ifidFlush;
  assign idex_flush   = ctl.idexFlush;
  assign memwb_bubble = ctl.memwbBubble;
  assign timeout_err  = (state == ERR);

  assign stallInc = !ctl.pcWrite && (state != ERR) && !reset;
  assign flushInc = ctl.ifidFlush;

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallInc),
    .clear (1'b0),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushInc),
    .clear (1'b0),
    .value (flush_cnt)
  );

endmodule
